// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: loader, CPU and InstructionMemory signals of the arbiter.
interface imem_arbiter_if #(parameter int AW = 8, parameter int DW = 16);
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;
    logic [DW-1:0] ld_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_rw_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          busy;
    logic          gnt_cpu;

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
        input  ld_ack, ld_rdata, cpu_ack, cpu_rdata, mem_rw_enable, mem_address, mem_data_in, busy, gnt_cpu
    );

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
        output ld_ack, ld_rdata, cpu_ack, cpu_rdata, mem_rw_enable, mem_address, mem_data_in, busy, gnt_cpu
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares single-port InstructionMemory between the loader and the CPU.
module imem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic          gnt_q, we_q, any_req, pick_cpu;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, ld_rd_q, cpu_rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Both requesting: round-robin favours whoever did not own the last transaction.
    always_comb begin
        any_req           = bus.ld_req || bus.cpu_req;
        pick_cpu          = bus.cpu_req && (!bus.ld_req || (FIXED_PRIO == 0 && !gnt_q));
        state_nx          = state == IDLE  ? (any_req ? ISSUE : IDLE) :
                            state == ISSUE ? (we_q ? DONE : WAIT) :
                            state == WAIT  ? (cnt == '0 ? DONE : WAIT) : IDLE;
        bus.busy          = state != IDLE;
        bus.gnt_cpu       = gnt_q;
        bus.ld_ack        = state == DONE && !gnt_q;
        bus.cpu_ack       = state == DONE && gnt_q;
        bus.mem_rw_enable = !(state == ISSUE && we_q);
        bus.mem_address   = addr_q;
        bus.mem_data_in   = wdata_q;
        bus.ld_rdata      = ld_rd_q;
        bus.cpu_rdata     = cpu_rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q    <= 1'b1;
            we_q     <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ld_rd_q  <= '0;
            cpu_rd_q <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt_q   <= pick_cpu;
                we_q    <= pick_cpu ? bus.cpu_we    : bus.ld_we;
                addr_q  <= pick_cpu ? bus.cpu_addr  : bus.ld_addr;
                wdata_q <= pick_cpu ? bus.cpu_wdata : bus.ld_wdata;
            end
            if (state == ISSUE) cnt <= CW'(READ_LAT - 1);
            if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0 && gnt_q)  cpu_rd_q <= bus.mem_data_out;
                if (cnt == '0 && !gnt_q) ld_rd_q  <= bus.mem_data_out;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of handshake timing, arbitration and read latency.
module tb_imem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass = 0;
    int   total = 0;

    imem_arbiter_if #(.AW(8), .DW(16)) b0 ();
    imem_arbiter_if #(.AW(8), .DW(16)) b1 ();
    imem_arbiter_if #(.AW(8), .DW(16)) b2 ();

    imem_arbiter #(.AW(8), .DW(16), .READ_LAT(1), .FIXED_PRIO(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    imem_arbiter #(.AW(8), .DW(16), .READ_LAT(1), .FIXED_PRIO(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    imem_arbiter #(.AW(8), .DW(16), .READ_LAT(3), .FIXED_PRIO(0)) u2 (.clk(clk), .reset(reset), .bus(b2));

    always #5 clk = ~clk;

    // Memory models: one-cycle registered read for u0/u1, three-stage read pipe for u2.
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];
    logic [15:0] p2 [2];

    always @(posedge clk) begin
        if (!b0.mem_rw_enable) mem0[b0.mem_address] <= b0.mem_data_in;
        if (!b1.mem_rw_enable) mem1[b1.mem_address] <= b1.mem_data_in;
        if (!b2.mem_rw_enable) mem2[b2.mem_address] <= b2.mem_data_in;
        b0.mem_data_out <= mem0[b0.mem_address];
        b1.mem_data_out <= mem1[b1.mem_address];
        p2[0] <= mem2[b2.mem_address];
        p2[1] <= p2[0];
        b2.mem_data_out <= p2[1];
    end

    task automatic init_inputs;
        b0.ld_req = 0; b0.ld_we = 0; b0.ld_addr = 0; b0.ld_wdata = 0;
        b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
        b1.ld_req = 0; b1.ld_we = 0; b1.ld_addr = 0; b1.ld_wdata = 0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
        b2.ld_req = 0; b2.ld_we = 0; b2.ld_addr = 0; b2.ld_wdata = 0;
        b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = 0; b2.cpu_wdata = 0;
    endtask

    task automatic do_reset;
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_reset;
        reset = 0;
        @(negedge clk); @(negedge clk);
        total++; if (b0.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", b0.busy); else pass++;
        total++; if (b0.gnt_cpu !== 1'b1) $display("FAIL rst_gnt_cpu got %b want 1", b0.gnt_cpu); else pass++;
        total++; if (b0.mem_rw_enable !== 1'b1) $display("FAIL rst_rw got %b want 1", b0.mem_rw_enable); else pass++;
        total++; if (b0.mem_address !== 8'h00 || b0.mem_data_in !== 16'h0000)
            $display("FAIL rst_bus got %h/%h want 00/0000", b0.mem_address, b0.mem_data_in); else pass++;
        total++; if ({b0.ld_ack, b0.cpu_ack} !== 2'b00 || b0.ld_rdata !== 16'h0 || b0.cpu_rdata !== 16'h0)
            $display("FAIL rst_outputs got ack=%b%b rd=%h/%h want 00 0000/0000", b0.ld_ack, b0.cpu_ack, b0.ld_rdata, b0.cpu_rdata); else pass++;
        reset = 1;
    endtask

    task automatic test_async_reset;
        @(negedge clk); b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 8'h03;
        @(negedge clk); b0.cpu_req = 0;
        @(negedge clk);
        total++; if (b0.busy !== 1'b1) $display("FAIL ar_busy_wait got %b want 1", b0.busy); else pass++;
        #1 reset = 0;
        #1;
        total++; if (b0.busy !== 1'b0) $display("FAIL ar_busy got %b want 0", b0.busy); else pass++;
        total++; if (b0.cpu_ack !== 1'b0 || b0.mem_rw_enable !== 1'b1)
            $display("FAIL ar_ack_rw got ack=%b rw=%b want 0 1", b0.cpu_ack, b0.mem_rw_enable); else pass++;
        @(negedge clk);
        total++; if (b0.cpu_ack !== 1'b0 || b0.cpu_rdata !== 16'h0)
            $display("FAIL ar_no_ack got ack=%b rd=%h want 0 0000", b0.cpu_ack, b0.cpu_rdata); else pass++;
        reset = 1;
    endtask

    task automatic test_ld_write;
        @(negedge clk); b0.ld_req = 1; b0.ld_we = 1; b0.ld_addr = 8'h00; b0.ld_wdata = 16'h000A;
        @(negedge clk);
        b0.ld_wdata = 16'hFFFF;
        total++; if (b0.mem_rw_enable !== 1'b0 || b0.mem_address !== 8'h00 || b0.mem_data_in !== 16'h000A)
            $display("FAIL wr_issue got rw=%b a=%h d=%h want 0 00 000a", b0.mem_rw_enable, b0.mem_address, b0.mem_data_in); else pass++;
        total++; if (b0.ld_ack !== 1'b0) $display("FAIL wr_early_ack got %b want 0", b0.ld_ack); else pass++;
        @(negedge clk);
        total++; if (b0.ld_ack !== 1'b1 || b0.cpu_ack !== 1'b0 || b0.gnt_cpu !== 1'b0)
            $display("FAIL wr_ack got ld=%b cpu=%b gnt=%b want 1 0 0", b0.ld_ack, b0.cpu_ack, b0.gnt_cpu); else pass++;
        total++; if (b0.mem_rw_enable !== 1'b1) $display("FAIL wr_done_rw got %b want 1", b0.mem_rw_enable); else pass++;
        b0.ld_req = 0;
        @(negedge clk);
        total++; if (b0.ld_ack !== 1'b0 || b0.busy !== 1'b0)
            $display("FAIL wr_after got ack=%b busy=%b want 0 0", b0.ld_ack, b0.busy); else pass++;
    endtask

    task automatic test_cpu_read;
        int rw_bad = 0;
        @(negedge clk); b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 8'h00;
        @(negedge clk);
        rw_bad += b0.mem_rw_enable !== 1'b1;
        total++; if (b0.mem_address !== 8'h00) $display("FAIL rd_addr got %h want 00", b0.mem_address); else pass++;
        b0.cpu_addr = 8'h55; b0.cpu_we = 1;
        @(negedge clk);
        rw_bad += b0.mem_rw_enable !== 1'b1;
        total++; if (b0.cpu_ack !== 1'b0) $display("FAIL rd_early_ack got %b want 0", b0.cpu_ack); else pass++;
        @(negedge clk);
        rw_bad += b0.mem_rw_enable !== 1'b1;
        total++; if (b0.cpu_ack !== 1'b1 || b0.cpu_rdata !== 16'h000A)
            $display("FAIL rd_ack got ack=%b rd=%h want 1 000a", b0.cpu_ack, b0.cpu_rdata); else pass++;
        total++; if (rw_bad !== 0) $display("FAIL rd_rw_low got %0d want 0", rw_bad); else pass++;
        b0.cpu_req = 0; b0.cpu_we = 0;
        @(negedge clk);
        total++; if (b0.cpu_ack !== 1'b0 || b0.cpu_rdata !== 16'h000A)
            $display("FAIL rd_hold got ack=%b rd=%h want 0 000a", b0.cpu_ack, b0.cpu_rdata); else pass++;
    endtask

    task automatic test_round_robin;
        logic exp_cpu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        b0.ld_req = 1; b0.ld_we = 1; b0.ld_addr = 8'h10; b0.ld_wdata = 16'h1111;
        b0.cpu_req = 1; b0.cpu_we = 1; b0.cpu_addr = 8'h11; b0.cpu_wdata = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!b0.ld_ack && !b0.cpu_ack && n < 10);
            total++; if (n !== 2) $display("FAIL rr_latency%0d got %0d want 2", k, n); else pass++;
            total++; if (b0.cpu_ack !== exp_cpu[k] || b0.ld_ack !== !exp_cpu[k])
                $display("FAIL rr_order%0d got ld=%b cpu=%b want cpu=%b", k, b0.ld_ack, b0.cpu_ack, exp_cpu[k]); else pass++;
            if (k == 3) begin b0.ld_req = 0; b0.cpu_req = 0; end
            @(negedge clk);
            total++; if ({b0.ld_ack, b0.cpu_ack} !== 2'b00)
                $display("FAIL rr_pulse%0d got %b%b want 00", k, b0.ld_ack, b0.cpu_ack); else pass++;
        end
    endtask

    task automatic test_fixed_prio;
        b1.ld_req = 1; b1.ld_we = 1; b1.ld_addr = 8'h20; b1.ld_wdata = 16'h3333;
        b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 8'h21; b1.cpu_wdata = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!b1.ld_ack && !b1.cpu_ack && n < 10);
            total++; if (n !== 2) $display("FAIL fp_latency%0d got %0d want 2", k, n); else pass++;
            total++; if (b1.cpu_ack !== (k == 3) || b1.ld_ack !== (k != 3))
                $display("FAIL fp_order%0d got ld=%b cpu=%b", k, b1.ld_ack, b1.cpu_ack); else pass++;
            if (k == 2) b1.ld_req = 0;
            if (k == 3) b1.cpu_req = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_read_lat3;
        int n = 0;
        logic [15:0] last_mdo = 16'h0;
        @(negedge clk); b2.ld_req = 1; b2.ld_we = 1; b2.ld_addr = 8'h05; b2.ld_wdata = 16'h1234;
        do begin @(negedge clk); n++; end while (!b2.ld_ack && n < 10);
        total++; if (n !== 2) $display("FAIL rl3_wr_latency got %0d want 2", n); else pass++;
        b2.ld_req = 0;
        @(negedge clk);
        b2.ld_req = 1; b2.ld_we = 0; b2.ld_addr = 8'h05; b2.ld_wdata = 16'h0000;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 4) last_mdo = b2.mem_data_out;
        end while (!b2.ld_ack && n < 12);
        total++; if (n !== 5) $display("FAIL rl3_latency got %0d want 5", n); else pass++;
        total++; if (b2.ld_rdata !== 16'h1234) $display("FAIL rl3_rdata got %h want 1234", b2.ld_rdata); else pass++;
        total++; if (b2.ld_rdata !== last_mdo) $display("FAIL rl3_last_wait got %h want %h", b2.ld_rdata, last_mdo); else pass++;
        b2.ld_req = 0;
        @(negedge clk);
        total++; if (b2.ld_ack !== 1'b0 || b2.ld_rdata !== 16'h1234)
            $display("FAIL rl3_hold got ack=%b rd=%h want 0 1234", b2.ld_ack, b2.ld_rdata); else pass++;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_async_reset();
        test_ld_write();
        test_cpu_read();
        test_round_robin();
        test_fixed_prio();
        test_read_lat3();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
